// File: rtl/arbitro_pkg.sv
// Shared definitions for the arbitro_1 / arbitro_2 arbiter pair: queue count,
// class-field placement and the one-hot queue encoder.
package arbitro_pkg;

  localparam int NUM_QUEUES = 4;

  // Class field sits in the top two bits of every word, counted down from the MSB.
  localparam int CLASS_MSB = 1;
  localparam int CLASS_LSB = 2;

  function automatic logic [NUM_QUEUES-1:0] onehot4(input logic [1:0] idx);
    logic [NUM_QUEUES-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arbitro_1_sel.sv
// Cyclic priority scan: first eligible queue starting at ptr and wrapping mod 4.
module arbitro_1_sel
  import arbitro_pkg::*;
(
  input  logic [1:0]            ptr,
  input  logic [NUM_QUEUES-1:0] eligible,
  output logic [1:0]            g,
  output logic                  valid
);

  logic [1:0] idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    g     = '0;
    valid = 1'b0;
    idx   = '0;
    // Scan farthest-first so the closest eligible queue to ptr wins last.
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (eligible[idx]) begin
        g     = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_1.sv
// Burst-weighted round-robin arbiter draining four FWFT queues into the
// intermediate FIFO, with combinational Pop and registered Push/data_out.
module arbitro_1
  import arbitro_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int BURST      = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [NUM_QUEUES-1:0] FIFO_empty,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  Almost_full,
  output logic [NUM_QUEUES-1:0] Pop,
  output logic                  Push,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [2:0] BURST_LEN = 3'(BURST);

  logic [1:0]            ptr;
  logic [2:0]            cnt;
  logic [1:0]            g;
  logic                  sel_valid;
  logic                  grant_ok;
  logic [2:0]            n;
  logic [DATA_WIDTH-1:0] sel_data;

  arbitro_1_sel u_sel (
    .ptr      (ptr),
    .eligible (~FIFO_empty),
    .g        (g),
    .valid    (sel_valid)
  );

  // Reset is part of the grant qualifier so Pop drops in the reset cycle itself.
  assign grant_ok = reset_L && !Almost_full && sel_valid;
  assign Pop      = grant_ok ? onehot4(g) : '0;
  assign n        = (g == ptr) ? cnt + 3'd1 : 3'd1;

  always_comb begin
    case (g)
      2'd0:    sel_data = data_in0;
      2'd1:    sel_data = data_in1;
      2'd2:    sel_data = data_in2;
      default: sel_data = data_in3;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      Push     <= 1'b0;
      data_out <= '0;
      ptr      <= '0;
      cnt      <= '0;
    end else if (grant_ok) begin
      Push     <= 1'b1;
      data_out <= sel_data;
      if (n == BURST_LEN) begin
        ptr <= g + 2'd1;
        cnt <= '0;
      end else begin
        ptr <= g;
        cnt <= n;
      end
    end else begin
      Push <= 1'b0;
    end
  end

endmodule
